// File: rtl/core_pkg.sv
// Shared core definitions: decoded operation encoding and writeback FSM states.
// Operation codes are fixed 6-bit values so other units can rely on them.
package core_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [5:0] {
    CU_LUI   = 6'h01, CU_AUIPC = 6'h02, CU_JAL   = 6'h03, CU_JALR  = 6'h04,
    CU_BEQ   = 6'h05, CU_BNE   = 6'h06, CU_BLT   = 6'h07, CU_BGE   = 6'h08,
    CU_BLTU  = 6'h09, CU_BGEU  = 6'h0A,
    CU_LB    = 6'h0B, CU_LH    = 6'h0C, CU_LW    = 6'h0D, CU_LBU   = 6'h0E,
    CU_LHU   = 6'h0F,
    CU_SB    = 6'h10, CU_SH    = 6'h11, CU_SW    = 6'h12,
    CU_ADDI  = 6'h13, CU_SLTI  = 6'h14, CU_SLTIU = 6'h15, CU_XORI  = 6'h16,
    CU_ORI   = 6'h17, CU_ANDI  = 6'h18, CU_SLLI  = 6'h19, CU_SRLI  = 6'h1A,
    CU_SRAI  = 6'h1B,
    CU_ADD   = 6'h1C, CU_SUB   = 6'h1D, CU_SLL   = 6'h1E, CU_SLT   = 6'h1F,
    CU_SLTU  = 6'h20, CU_XOR   = 6'h21, CU_SRL   = 6'h22, CU_SRA   = 6'h23,
    CU_OR    = 6'h24, CU_AND   = 6'h25,
    CU_ERROR = 6'h3F
  } cuOPType;

  typedef enum logic {
    WB_IDLE     = 1'b0,
    WB_WAIT_MEM = 1'b1
  } wb_state_t;

  function automatic logic is_load(cuOPType op);
    return op inside {CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU};
  endfunction

  // Stores, branches and decode errors never touch the register file.
  function automatic logic writes_rd(cuOPType op);
    return !(op inside {CU_SB, CU_SH, CU_SW, CU_BEQ, CU_BNE, CU_BLT, CU_BGE,
                        CU_BLTU, CU_BGEU, CU_ERROR});
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Execute/memory-side bundle of the writeback stage; the stage uses the slave view.
interface wb_stage_if #(
  parameter int XLEN    = core_pkg::XLEN_DEFAULT,
  parameter int RADDR_W = 5
);
  localparam int OFF_W = $clog2(XLEN/8);

  logic                 in_valid;
  logic                 in_ready;
  core_pkg::cuOPType    cuOP;
  logic [RADDR_W-1:0]   rd;
  logic [XLEN-1:0]      pc;
  logic [XLEN-1:0]      aluOut;
  logic [XLEN-1:0]      imm;
  logic [OFF_W-1:0]     addr_off;
  logic                 mem_req;
  logic                 mem_ack;
  logic [XLEN-1:0]      memload;
  logic                 flush;
  logic                 wb_en;
  logic [RADDR_W-1:0]   wb_rd;
  logic [XLEN-1:0]      wb_data;
  logic                 misalign;

  modport master (
    output in_valid, cuOP, rd, pc, aluOut, imm, addr_off, mem_ack, memload, flush,
    input  in_ready, mem_req, wb_en, wb_rd, wb_data, misalign
  );

  modport slave (
    input  in_valid, cuOP, rd, pc, aluOut, imm, addr_off, mem_ack, memload, flush,
    output in_ready, mem_req, wb_en, wb_rd, wb_data, misalign
  );

endinterface

// File: rtl/wb_stage_load_extend.sv
// Combinational load lane select and sign/zero extension with alignment check.
module load_extend import core_pkg::*; #(
  parameter  int XLEN  = XLEN_DEFAULT,
  localparam int OFF_W = $clog2(XLEN/8)
) (
  input  cuOPType          op_i,
  input  logic [OFF_W-1:0] off_i,
  input  logic [XLEN-1:0]  memload_i,
  output logic [XLEN-1:0]  data_o,
  output logic             misaligned_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] word_lane;

  assign byte_lane = 8'(memload_i >> {off_i, 3'b000});
  assign half_lane = 16'(memload_i >> {off_i, 3'b000});
  assign word_lane = 32'(memload_i >> {off_i, 3'b000});

  always_comb begin
    data_o       = '0;
    misaligned_o = 1'b0;
    case (op_i)
      CU_LB:  data_o = XLEN'(signed'(byte_lane));
      CU_LBU: data_o = XLEN'(byte_lane);
      CU_LH: begin
        data_o       = XLEN'(signed'(half_lane));
        misaligned_o = off_i[0];
      end
      CU_LHU: begin
        data_o       = XLEN'(half_lane);
        misaligned_o = off_i[0];
      end
      // Sign extension is a no-op at XLEN=32, so one form covers both widths.
      CU_LW: begin
        data_o       = XLEN'(signed'(word_lane));
        misaligned_o = (off_i[1:0] != 2'b00);
      end
      default: begin
        data_o       = '0;
        misaligned_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: result select, load handshake FSM and registered register-file write port.
module wb_stage import core_pkg::*; #(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int RADDR_W = 5
) (
  input logic       clk,
  input logic       nRst,
  wb_stage_if.slave bus
);

  localparam int OFF_W = $clog2(XLEN/8);

  wb_state_t          state_q, state_d;
  cuOPType            pend_op_q;
  logic [RADDR_W-1:0] pend_rd_q;
  logic [OFF_W-1:0]   pend_off_q;
  logic               pend_ld;

  logic               wb_en_q, wb_en_d;
  logic [RADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]    wb_data_q, wb_data_d;
  logic               misalign_q, misalign_d;

  cuOPType            ext_op;
  logic [OFF_W-1:0]   ext_off;
  logic [XLEN-1:0]    ext_data;
  logic               ext_mis;
  logic [XLEN-1:0]    imm_u;
  logic [XLEN-1:0]    exe_res;
  logic               unused_imm_hi;

  // In IDLE the extender only screens the incoming op for alignment; in WAIT_MEM it formats the returned word.
  assign ext_op  = (state_q == WB_IDLE) ? bus.cuOP     : pend_op_q;
  assign ext_off = (state_q == WB_IDLE) ? bus.addr_off : pend_off_q;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .op_i         (ext_op),
    .off_i        (ext_off),
    .memload_i    (bus.memload),
    .data_o       (ext_data),
    .misaligned_o (ext_mis)
  );

  assign imm_u         = XLEN'(signed'({bus.imm[19:0], 12'h000}));
  assign unused_imm_hi = ^bus.imm[XLEN-1:20];

  always_comb begin
    case (bus.cuOP)
      CU_LUI:          exe_res = imm_u;
      CU_AUIPC:        exe_res = bus.pc + imm_u;
      CU_JAL, CU_JALR: exe_res = bus.pc + XLEN'(4);
      default:         exe_res = bus.aluOut;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pend_ld    = 1'b0;
    wb_en_d    = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    misalign_d = 1'b0;
    case (state_q)
      WB_IDLE: begin
        if (bus.in_valid && !bus.flush) begin
          if (is_load(bus.cuOP)) begin
            if (ext_mis) begin
              misalign_d = 1'b1;
            end else begin
              state_d = WB_WAIT_MEM;
              pend_ld = 1'b1;
            end
          end else if (writes_rd(bus.cuOP) && (bus.rd != '0)) begin
            wb_en_d   = 1'b1;
            wb_rd_d   = bus.rd;
            wb_data_d = exe_res;
          end
        end
      end
      WB_WAIT_MEM: begin
        // A flush squashes the pending load even when its data arrives this cycle.
        if (bus.flush) begin
          state_d = WB_IDLE;
        end else if (bus.mem_ack) begin
          state_d = WB_IDLE;
          if (pend_rd_q != '0) begin
            wb_en_d   = 1'b1;
            wb_rd_d   = pend_rd_q;
            wb_data_d = ext_data;
          end
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= WB_IDLE;
      wb_en_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wb_en_q    <= wb_en_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      misalign_q <= misalign_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pend_ld) begin
      pend_op_q  <= bus.cuOP;
      pend_rd_q  <= bus.rd;
      pend_off_q <= bus.addr_off;
    end
  end

  assign bus.in_ready = (state_q == WB_IDLE);
  assign bus.mem_req  = (state_q == WB_WAIT_MEM);
  assign bus.wb_en    = wb_en_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.misalign = misalign_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed vector table, hand-written corner sequences and
// randomized transactions against an arithmetic reference model.
module tb_wb_stage;
  import core_pkg::*;

  logic clk = 1'b0;
  logic nRst;
  always #5 clk = ~clk;

  wb_stage_if #(.XLEN(32), .RADDR_W(5)) b32 ();
  wb_stage_if #(.XLEN(64), .RADDR_W(5)) b64 ();

  wb_stage #(.XLEN(32), .RADDR_W(5)) dut32 (.clk(clk), .nRst(nRst), .bus(b32));
  wb_stage #(.XLEN(64), .RADDR_W(5)) dut64 (.clk(clk), .nRst(nRst), .bus(b64));

  typedef struct {
    cuOPType     op;
    logic [4:0]  rd;
    logic [63:0] pc, alu, imm, mem;
    int          off;
    int          dly;
    logic        exp_en;
    logic [63:0] exp_data;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic        en;
    logic [63:0] data;
    logic        mis;
  } res_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [4:0]  last_rd   = '0;
  logic [63:0] last_data = '0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(cuOPType op, logic [4:0] rd, logic [63:0] pc, logic [63:0] alu,
                              logic [63:0] imm, int off, logic [63:0] mem, int dly,
                              logic en, logic [63:0] d, logic mis);
    vec_t v;
    v.op = op; v.rd = rd; v.pc = pc; v.alu = alu; v.imm = imm; v.off = off;
    v.mem = mem; v.dly = dly; v.exp_en = en; v.exp_data = d; v.exp_mis = mis;
    return v;
  endfunction

  function automatic logic [63:0] sx(logic [63:0] v, int bits);
    if (((v >> (bits - 1)) & 64'd1) != 0) return v | (~64'd0 << bits);
    return v;
  endfunction

  function automatic logic is_ld(cuOPType op);
    return (op == CU_LB) || (op == CU_LH) || (op == CU_LW) || (op == CU_LBU) || (op == CU_LHU);
  endfunction

  // Reference: what the register file should see for one instruction, from the ISA rules.
  function automatic res_t model(int xl, vec_t v);
    res_t        r;
    logic [63:0] mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    logic [63:0] lane = v.mem >> (8 * v.off);
    logic [63:0] uimm = sx((v.imm & 64'hF_FFFF) * 64'd4096, 32);
    r.en = 1'b1; r.mis = 1'b0; r.data = v.alu;
    case (v.op)
      CU_LUI:          r.data = uimm;
      CU_AUIPC:        r.data = v.pc + uimm;
      CU_JAL, CU_JALR: r.data = v.pc + 64'd4;
      CU_LB:           r.data = sx(lane & 64'hFF, 8);
      CU_LBU:          r.data = lane & 64'hFF;
      CU_LH:  begin r.data = sx(lane & 64'hFFFF, 16); r.mis = (v.off % 2) != 0; end
      CU_LHU: begin r.data = lane & 64'hFFFF;         r.mis = (v.off % 2) != 0; end
      CU_LW:  begin r.data = sx(lane & 64'hFFFF_FFFF, 32); r.mis = (v.off % 4) != 0; end
      CU_SB, CU_SH, CU_SW, CU_BEQ, CU_BNE, CU_BLT, CU_BGE, CU_BLTU, CU_BGEU, CU_ERROR:
        r.en = 1'b0;
      default: ;
    endcase
    r.data = r.data & mask;
    if (r.mis || v.rd == 5'd0) r.en = 1'b0;
    return r;
  endfunction

  task automatic txn32(vec_t v);
    logic exp_req;
    exp_req        = is_ld(v.op) && !v.exp_mis;
    b32.in_valid   = 1'b1;
    b32.cuOP       = v.op;
    b32.rd         = v.rd;
    b32.pc         = v.pc[31:0];
    b32.aluOut     = v.alu[31:0];
    b32.imm        = v.imm[31:0];
    b32.addr_off   = 2'(v.off);
    b32.memload    = v.mem[31:0];
    step();
    b32.in_valid   = 1'b0;
    chk("mem_req_after_accept", 64'(b32.mem_req), 64'(exp_req));
    if (b32.mem_req) begin
      for (int i = 0; i < v.dly; i++) begin
        chk("in_ready_while_waiting", 64'(b32.in_ready), 64'd0);
        step();
      end
      b32.mem_ack = 1'b1;
      step();
      b32.mem_ack = 1'b0;
    end
    chk("wb_en", 64'(b32.wb_en), 64'(v.exp_en));
    chk("misalign", 64'(b32.misalign), 64'(v.exp_mis));
    chk("in_ready_after", 64'(b32.in_ready), 64'd1);
    if (v.exp_en) begin
      last_rd   = v.rd;
      last_data = v.exp_data;
    end
    chk("wb_rd", 64'(b32.wb_rd), 64'(last_rd));
    chk("wb_data", 64'(b32.wb_data), last_data);
    step();
    chk("wb_en_one_cycle", 64'(b32.wb_en), 64'd0);
    chk("misalign_one_cycle", 64'(b32.misalign), 64'd0);
  endtask

  vec_t    tbl[16];
  cuOPType ops[20] = '{CU_LUI, CU_AUIPC, CU_JAL, CU_JALR, CU_BEQ, CU_BGEU, CU_LB, CU_LH,
                      CU_LW, CU_LBU, CU_LHU, CU_SB, CU_SW, CU_ADDI, CU_XORI, CU_ADD,
                      CU_SUB, CU_SRA, CU_AND, CU_ERROR};

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        v;
    res_t        r;
    logic [63:0] a;

    tbl[0]  = mk(CU_ADDI,  5'd5,  64'h0,         64'h1234,     64'h0,     0, 64'h0,          0, 1'b1, 64'h0000_1234, 1'b0);
    tbl[1]  = mk(CU_ADDI,  5'd0,  64'h0,         64'h5555,     64'h0,     0, 64'h0,          0, 1'b0, 64'h0,         1'b0);
    tbl[2]  = mk(CU_LUI,   5'd1,  64'h0,         64'h0,        64'hFFFFF, 0, 64'h0,          0, 1'b1, 64'hFFFF_F000, 1'b0);
    tbl[3]  = mk(CU_AUIPC, 5'd2,  64'h100,       64'h0,        64'h1,     0, 64'h0,          0, 1'b1, 64'h0000_1100, 1'b0);
    tbl[4]  = mk(CU_JAL,   5'd3,  64'hFFFF_FFFC, 64'h0,        64'h0,     0, 64'h0,          0, 1'b1, 64'h0000_0000, 1'b0);
    tbl[5]  = mk(CU_LB,    5'd4,  64'h0,         64'h0,        64'h0,     2, 64'h0080_0000,  3, 1'b1, 64'hFFFF_FF80, 1'b0);
    tbl[6]  = mk(CU_LBU,   5'd4,  64'h0,         64'h0,        64'h0,     2, 64'h0080_0000,  3, 1'b1, 64'h0000_0080, 1'b0);
    tbl[7]  = mk(CU_LH,    5'd6,  64'h0,         64'h0,        64'h0,     1, 64'h8001_0000,  0, 1'b0, 64'h0,         1'b1);
    tbl[8]  = mk(CU_LH,    5'd6,  64'h0,         64'h0,        64'h0,     2, 64'h8001_0000,  1, 1'b1, 64'hFFFF_8001, 1'b0);
    tbl[9]  = mk(CU_SW,    5'd7,  64'h0,         64'h7777,     64'h0,     0, 64'h0,          0, 1'b0, 64'h0,         1'b0);
    tbl[10] = mk(CU_BEQ,   5'd8,  64'h0,         64'h1,        64'h0,     0, 64'h0,          0, 1'b0, 64'h0,         1'b0);
    tbl[11] = mk(CU_LW,    5'd9,  64'h0,         64'h0,        64'h0,     0, 64'hDEAD_BEEF,  1, 1'b1, 64'hDEAD_BEEF, 1'b0);
    tbl[12] = mk(CU_LHU,   5'd10, 64'h0,         64'h0,        64'h0,     2, 64'h8001_0000,  0, 1'b1, 64'h0000_8001, 1'b0);
    tbl[13] = mk(CU_LW,    5'd11, 64'h0,         64'h0,        64'h0,     2, 64'h1234_5678,  0, 1'b0, 64'h0,         1'b1);
    tbl[14] = mk(CU_ERROR, 5'd11, 64'h0,         64'h9999,     64'h0,     0, 64'h0,          0, 1'b0, 64'h0,         1'b0);
    tbl[15] = mk(CU_JALR,  5'd12, 64'h2000,      64'h0,        64'h0,     0, 64'h0,          0, 1'b1, 64'h0000_2004, 1'b0);

    nRst = 1'b0;
    b32.in_valid = 1'b0; b32.cuOP = CU_ADDI; b32.rd = '0; b32.pc = '0; b32.aluOut = '0;
    b32.imm = '0; b32.addr_off = '0; b32.mem_ack = 1'b0; b32.memload = '0; b32.flush = 1'b0;
    b64.in_valid = 1'b0; b64.cuOP = CU_ADDI; b64.rd = '0; b64.pc = '0; b64.aluOut = '0;
    b64.imm = '0; b64.addr_off = '0; b64.mem_ack = 1'b0; b64.memload = '0; b64.flush = 1'b0;
    #12;
    chk("reset_wb_en", 64'(b32.wb_en), 64'd0);
    chk("reset_wb_rd", 64'(b32.wb_rd), 64'd0);
    chk("reset_wb_data", 64'(b32.wb_data), 64'd0);
    chk("reset_misalign", 64'(b32.misalign), 64'd0);
    chk("reset_mem_req", 64'(b32.mem_req), 64'd0);
    chk("reset_in_ready", 64'(b32.in_ready), 64'd1);
    chk("reset_in_ready_64", 64'(b64.in_ready), 64'd1);
    nRst = 1'b1;
    step();

    for (int i = 0; i < 16; i++) txn32(tbl[i]);

    // Flush in IDLE drops the offered instruction.
    b32.in_valid = 1'b1; b32.cuOP = CU_ADDI; b32.rd = 5'd5; b32.aluOut = 32'h77; b32.flush = 1'b1;
    step();
    b32.in_valid = 1'b0; b32.flush = 1'b0;
    chk("flush_idle_wb_en", 64'(b32.wb_en), 64'd0);
    chk("flush_idle_mem_req", 64'(b32.mem_req), 64'd0);

    // mem_ack while idle has no effect.
    b32.mem_ack = 1'b1; b32.memload = 32'hFFFF_FFFF;
    step();
    b32.mem_ack = 1'b0;
    chk("ack_idle_wb_en", 64'(b32.wb_en), 64'd0);
    chk("ack_idle_mem_req", 64'(b32.mem_req), 64'd0);

    // Flush and mem_ack together in WAIT_MEM: flush wins.
    b32.in_valid = 1'b1; b32.cuOP = CU_LB; b32.rd = 5'd4; b32.addr_off = 2'd0; b32.memload = 32'h55;
    step();
    b32.in_valid = 1'b0;
    chk("flush_wait_mem_req", 64'(b32.mem_req), 64'd1);
    step();
    b32.flush = 1'b1; b32.mem_ack = 1'b1;
    step();
    b32.flush = 1'b0; b32.mem_ack = 1'b0;
    chk("flush_ack_wb_en", 64'(b32.wb_en), 64'd0);
    chk("flush_ack_in_ready", 64'(b32.in_ready), 64'd1);
    chk("flush_ack_mem_req", 64'(b32.mem_req), 64'd0);
    txn32(mk(CU_ADDI, 5'd5, 64'h0, 64'hABC, 64'h0, 0, 64'h0, 0, 1'b1, 64'hABC, 1'b0));

    // Reset asserted mid-wait clears everything without a clock edge.
    b32.in_valid = 1'b1; b32.cuOP = CU_LW; b32.rd = 5'd9; b32.addr_off = 2'd0;
    step();
    b32.in_valid = 1'b0;
    chk("rst_wait_mem_req", 64'(b32.mem_req), 64'd1);
    #2;
    nRst = 1'b0;
    #1;
    chk("rst_async_wb_en", 64'(b32.wb_en), 64'd0);
    chk("rst_async_wb_rd", 64'(b32.wb_rd), 64'd0);
    chk("rst_async_wb_data", 64'(b32.wb_data), 64'd0);
    chk("rst_async_misalign", 64'(b32.misalign), 64'd0);
    chk("rst_async_mem_req", 64'(b32.mem_req), 64'd0);
    chk("rst_async_in_ready", 64'(b32.in_ready), 64'd1);
    nRst = 1'b1;
    last_rd = '0; last_data = '0;
    step();

    for (int n = 0; n < 300; n++) begin
      v = mk(ops[$urandom_range(0, 19)], 5'($urandom_range(0, 31)), 64'($urandom),
             64'($urandom), 64'($urandom), int'($urandom_range(0, 3)), 64'($urandom),
             int'($urandom_range(0, 3)), 1'b0, 64'h0, 1'b0);
      r = model(32, v);
      v.exp_en = r.en; v.exp_data = r.data; v.exp_mis = r.mis;
      txn32(v);
    end

    // XLEN=64: word load from the upper half, sign-extended.
    b64.in_valid = 1'b1; b64.cuOP = CU_LW; b64.rd = 5'd1; b64.addr_off = 3'd4;
    b64.memload = 64'h8000_0000_0000_0000;
    step();
    b64.in_valid = 1'b0;
    chk("x64_lw_mem_req", 64'(b64.mem_req), 64'd1);
    b64.mem_ack = 1'b1;
    step();
    b64.mem_ack = 1'b0;
    chk("x64_lw_wb_en", 64'(b64.wb_en), 64'd1);
    chk("x64_lw_wb_data", b64.wb_data, 64'hFFFF_FFFF_8000_0000);

    b64.in_valid = 1'b1; b64.cuOP = CU_LUI; b64.rd = 5'd2; b64.imm = 64'hFFFFF;
    step();
    chk("x64_lui_wb_data", b64.wb_data, model(64, mk(CU_LUI, 5'd2, 64'h0, 64'h0, 64'hFFFFF,
                                                      0, 64'h0, 0, 1'b0, 64'h0, 1'b0)).data);

    // Back-to-back ALU stream: one result per cycle.
    b64.cuOP = CU_ADD;
    for (int k = 0; k < 8; k++) begin
      a = {$urandom, $urandom};
      b64.aluOut = a; b64.rd = 5'(k + 1);
      step();
      chk("x64_stream_wb_en", 64'(b64.wb_en), 64'd1);
      chk("x64_stream_wb_data", b64.wb_data, a);
      chk("x64_stream_wb_rd", 64'(b64.wb_rd), 64'(k + 1));
    end
    b64.in_valid = 1'b0;
    step();
    chk("x64_stream_end_wb_en", 64'(b64.wb_en), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
